// File: rtl/cbuf_acq_sequencer_if.sv
// Mux / sample-source / write-FIFO handshake bundle between cbuf_acq_sequencer and the ADC data path.
interface cbuf_acq_sequencer_if;
  logic src_valid;
  logic fifo_afull;
  logic src_rd_en;
  logic select_fill_hdr;
  logic select_waveform_hdr;
  logic select_dat;
  logic select_checksum;
  logic checksum_update;
  logic fifo_wr_en;

  modport master (
    input  src_valid, fifo_afull,
    output src_rd_en, select_fill_hdr, select_waveform_hdr, select_dat,
           select_checksum, checksum_update, fifo_wr_en
  );

  modport slave (
    output src_valid, fifo_afull,
    input  src_rd_en, select_fill_hdr, select_waveform_hdr, select_dat,
           select_checksum, checksum_update, fifo_wr_en
  );
endinterface

// File: rtl/cbuf_acq_sequencer.sv
// Sequences one CBUF fill: fill header, waveform header, N data bursts, checksum, into the DDR3 write FIFO.
// Optional stall watchdog enabled by defining CBUF_TIMEOUT_EN.
module cbuf_acq_sequencer #(
  parameter int NB_W        = 14,
  parameter int FILL_W      = 24,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              trigger,
  input  logic [NB_W-1:0]   num_bursts,
  cbuf_acq_sequencer_if.master mux,
  output logic              busy,
  output logic              fill_done,
  output logic [FILL_W-1:0] fill_count,
  output logic              trig_missed,
  output logic              timeout_err
);
  typedef enum logic [2:0] {S_IDLE, S_FHDR, S_WHDR, S_DATA, S_CKSUM, S_DONE} state_t;

  state_t          state;
  logic            sel_fh, sel_wh, sel_d, sel_ck, wr_en;
  logic [NB_W-1:0] nb_lat, bcnt;
  logic            afull, valid;
  logic            go_fh, go_wh, go_d, go_ck;

  assign afull = mux.fifo_afull;
  assign valid = mux.src_valid;

  // Select to be registered at the next edge; the select register itself marks "issued this cycle".
  always_comb begin
    go_fh = 1'b0;
    go_wh = 1'b0;
    go_d  = 1'b0;
    go_ck = 1'b0;
    unique case (state)
      S_IDLE:  go_fh = trigger && enable && !afull;
      S_FHDR:  if (sel_fh) go_wh = !afull; else go_fh = !afull;
      S_WHDR:  if (!sel_wh) go_wh = !afull;
               else if (nb_lat == '0) go_ck = !afull;
               else go_d = valid && !afull;
      S_DATA:  if (bcnt == nb_lat) go_ck = !afull; else go_d = valid && !afull;
      S_CKSUM: if (!sel_ck) go_ck = !afull;
      default: ;
    endcase
  end

`ifdef CBUF_TIMEOUT_EN
  logic [31:0] wd;
  logic        stall;
  assign stall = (state inside {S_FHDR, S_WHDR, S_DATA, S_CKSUM})
               && !(go_fh || go_wh || go_d || go_ck)
               && !(state == S_CKSUM && sel_ck);
`else
  logic unused_cfg;
  assign unused_cfg  = ^TIMEOUT_CYC;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      sel_fh      <= 1'b0;
      sel_wh      <= 1'b0;
      sel_d       <= 1'b0;
      sel_ck      <= 1'b0;
      wr_en       <= 1'b0;
      nb_lat      <= '0;
      bcnt        <= '0;
      busy        <= 1'b0;
      fill_done   <= 1'b0;
      fill_count  <= '0;
      trig_missed <= 1'b0;
`ifdef CBUF_TIMEOUT_EN
      wd          <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      sel_fh    <= go_fh;
      sel_wh    <= go_wh;
      sel_d     <= go_d;
      sel_ck    <= go_ck;
      wr_en     <= sel_fh | sel_wh | sel_d | sel_ck;
      fill_done <= 1'b0;
      if (go_d) bcnt <= bcnt + 1'b1;
      if (trigger && state != S_IDLE) trig_missed <= 1'b1;
      unique case (state)
        S_IDLE: if (trigger && enable) begin
          state  <= S_FHDR;
          nb_lat <= num_bursts;
          bcnt   <= '0;
          busy   <= 1'b1;
        end
        S_FHDR:  if (sel_fh) state <= S_WHDR;
        S_WHDR:  if (sel_wh) state <= (nb_lat == '0) ? S_CKSUM : S_DATA;
        S_DATA:  if (bcnt == nb_lat) state <= S_CKSUM;
        S_CKSUM: if (sel_ck) begin
          state      <= S_DONE;
          fill_done  <= 1'b1;
          fill_count <= fill_count + 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
`ifdef CBUF_TIMEOUT_EN
      // On expiry the checksum is issued in the slot of the final stall cycle.
      if (!stall) wd <= '0;
      else if (wd == 32'(TIMEOUT_CYC - 1)) begin
        wd          <= '0;
        timeout_err <= 1'b1;
        state       <= S_CKSUM;
        sel_ck      <= !afull;
      end else wd <= wd + 1'b1;
`endif
    end
  end

  assign mux.select_fill_hdr     = sel_fh;
  assign mux.select_waveform_hdr = sel_wh;
  assign mux.select_dat          = sel_d;
  assign mux.select_checksum     = sel_ck;
  assign mux.src_rd_en           = sel_d;
  assign mux.checksum_update     = sel_d;
  assign mux.fifo_wr_en          = wr_en;
endmodule

// File: tb/tb_cbuf_acq_sequencer.sv
// Bench for cbuf_acq_sequencer: per-fill token scoreboard checked every cycle plus directed latency checks.
`timescale 1ns/1ps
module tb_cbuf_acq_sequencer;
  localparam int TB_TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        trigger = 1'b0;
  logic [13:0] num_bursts = '0;
  logic        busy, fill_done, trig_missed, timeout_err;
  logic [23:0] fill_count;

  cbuf_acq_sequencer_if bus();

  cbuf_acq_sequencer #(.NB_W(14), .FILL_W(24), .TIMEOUT_CYC(TB_TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .trigger(trigger), .num_bursts(num_bursts),
    .mux(bus.master), .busy(busy), .fill_done(fill_done), .fill_count(fill_count),
    .trig_missed(trig_missed), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: each accepted trigger queues the write tokens F,W,D*N,C; any visible select must match the head.
  byte  q[$];
  byte  tok;
  bit   m_busy, m_missed, done_exp, p_pop, p_afull, p_valid, popped_c;
  int   m_fills, n_d, n_wr, f_cyc, c_cyc, done_cyc, done_seen;
  logic [5:0] v_act, v_exp;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_outs", {bus.select_fill_hdr, bus.select_waveform_hdr, bus.select_dat, bus.select_checksum,
                       bus.src_rd_en, bus.checksum_update, bus.fifo_wr_en, busy, fill_done,
                       trig_missed, timeout_err}, 0);
      chk("rst_fill_count", fill_count, 0);
      q.delete();
      m_busy = 0; m_missed = 0; done_exp = 0; p_pop = 0; m_fills = 0;
    end else begin
      v_act = {bus.select_fill_hdr, bus.select_waveform_hdr, bus.select_dat, bus.select_checksum,
               bus.src_rd_en, bus.checksum_update};
      v_exp = '0;
      popped_c = 0;
      chk("fifo_wr_en", bus.fifo_wr_en, p_pop);
      n_wr += bus.fifo_wr_en;
`ifdef CBUF_TIMEOUT_EN
      if (bus.select_checksum && timeout_err && q.size() > 0 && q[0] == "D")
        while (q.size() > 0 && q[0] == "D") q.pop_front();
`endif
      if (v_act != '0) begin
        tok = (q.size() > 0) ? q.pop_front() : " ";
        case (tok)
          "F": begin v_exp = 6'b100000; f_cyc = cyc; end
          "W": v_exp = 6'b010000;
          "D": begin v_exp = 6'b001011; n_d++; chk("valid_gate", p_valid, 1); end
          "C": begin v_exp = 6'b000100; c_cyc = cyc; popped_c = 1; end
          default: v_exp = '0;
        endcase
        chk("afull_gate", p_afull, 0);
      end
      chk("selects", v_act, v_exp);
      chk("fill_done", fill_done, done_exp);
      if (done_exp) begin m_fills++; done_cyc = cyc; done_seen++; end
      chk("busy", busy, m_busy);
      chk("trig_missed", trig_missed, m_missed);
      chk("fill_count", fill_count, m_fills);
`ifndef CBUF_TIMEOUT_EN
      chk("timeout_err", timeout_err, 0);
`endif
      if (trigger && m_busy) m_missed = 1;
      if (done_exp) m_busy = 0;
      else if (trigger && enable && !m_busy) begin
        m_busy = 1; n_d = 0; n_wr = 0;
        q.push_back("F"); q.push_back("W");
        for (int i = 0; i < int'(num_bursts); i++) q.push_back("D");
        q.push_back("C");
      end
      done_exp = popped_c;
      p_pop    = (v_act != '0);
    end
    p_afull = bus.fifo_afull;
    p_valid = bus.src_valid;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fire(input int n, output int t);
    num_bursts = 14'(n);
    trigger = 1'b1;
    t = cyc;
    tick();
    trigger = 1'b0;
  endtask

  task automatic wait_done(input int lim, input bit toggle);
    int start;
    start = done_seen;
    for (int i = 0; i < lim && done_seen == start; i++) begin
      if (toggle) bus.src_valid = ~bus.src_valid;
      tick();
    end
    chk("done_reached", done_seen != start, 1);
  endtask

  int t;

  initial begin
    bus.src_valid  = 1'b1;
    bus.fifo_afull = 1'b0;
    repeat (3) tick();
    chk("reset_busy", busy, 0);
    reset = 1'b0;
    enable = 1'b1;
    tick();

    // 1: N=4, no stalls
    fire(4, t);
    wait_done(40, 0);
    chk("t1_fhdr_cyc", f_cyc - t, 1);
    chk("t1_cksum_cyc", c_cyc - t, 7);
    chk("t1_done_cyc", done_cyc - t, 8);
    chk("t1_n_dat", n_d, 4);
    chk("t1_n_wr", n_wr, 7);
    chk("t1_fill_count", fill_count, 1);

    // 2: N=0 -> F, W, C only
    tick();
    fire(0, t);
    wait_done(40, 0);
    chk("t2_cksum_cyc", c_cyc - t, 3);
    chk("t2_done_cyc", done_cyc - t, 4);
    chk("t2_n_wr", n_wr, 3);
    chk("t2_n_dat", n_d, 0);

    // 3: N=8, src_valid toggling every cycle
    tick();
    bus.src_valid = 1'b0;
    fire(8, t);
    wait_done(80, 1);
    chk("t3_n_dat", n_d, 8);
    chk("t3_n_wr", n_wr, 11);
    bus.src_valid = 1'b1;

    // 4: N=6, fifo_afull high 5 cycles from the 3rd burst
    tick();
    fire(6, t);
    repeat (4) tick();
    bus.fifo_afull = 1'b1;
    repeat (5) tick();
    bus.fifo_afull = 1'b0;
    wait_done(40, 0);
    chk("t4_done_cyc", done_cyc - t, 6 + 4 + 5);
    chk("t4_n_wr", n_wr, 9);
    chk("t4_fill_count", fill_count, 4);

    // 5: trigger with enable=0 dropped silently; trigger during DATA flagged and not queued
    tick();
    enable = 1'b0;
    fire(3, t);
    repeat (3) tick();
    chk("t5_dis_busy", busy, 0);
    chk("t5_dis_missed", trig_missed, 0);
    enable = 1'b1;
    fire(3, t);
    tick(); tick();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    wait_done(40, 0);
    repeat (10) tick();
    chk("t5_missed", trig_missed, 1);
    chk("t5_fill_count", fill_count, 5);
    chk("t5_idle", busy, 0);

    // 6: asynchronous reset during DATA
    fire(5, t);
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    chk("t6_async_outs", {bus.select_dat, bus.src_rd_en, bus.checksum_update, bus.fifo_wr_en, busy,
                          trig_missed}, 0);
    chk("t6_fill_count", fill_count, 0);
    tick();
    reset = 1'b0;
    tick();
    fire(2, t);
    wait_done(40, 0);
    chk("t6_recover_count", fill_count, 1);

    // 7: source stuck low in DATA
    tick();
    bus.src_valid = 1'b0;
    fire(4, t);
`ifdef CBUF_TIMEOUT_EN
    wait_done(80, 0);
    chk("t7_timeout_err", timeout_err, 1);
    chk("t7_cksum_cyc", c_cyc - t, 2 + TB_TO);
    chk("t7_n_dat", n_d, 0);
    chk("t7_n_wr", n_wr, 3);
    chk("t7_fill_count", fill_count, 2);
`else
    repeat (40) tick();
    chk("t7_stalled_busy", busy, 1);
    chk("t7_no_timeout", timeout_err, 0);
    bus.src_valid = 1'b1;
    wait_done(40, 0);
    chk("t7_n_dat", n_d, 4);
    chk("t7_fill_count", fill_count, 2);
`endif
    bus.src_valid = 1'b1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end
endmodule
